// File: rtl/uart_tx.sv
// UART transmitter: latches a byte on a valid/busy handshake and shifts out
// start bit, DATA_width data bits LSB first, optional parity bit and one stop bit.
// The bit period is Prescale clk cycles, with 0 and 1 both meaning one cycle.
// TX_OUT and busy are registered. They are derived from the next-state values,
// so the start bit appears on the edge right after the request is accepted.
module uart_tx #(
  parameter int unsigned Prescale_width = 6,
  parameter int unsigned DATA_width     = 8,
  parameter int unsigned n_bits         = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [Prescale_width-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [DATA_width-1:0]     P_DATA,
  input  logic                      Data_Valid,
  output logic                      TX_OUT,
  output logic                      busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic [Prescale_width-1:0] PresOne = Prescale_width'(1);
  localparam logic [n_bits-1:0]         BitOne  = n_bits'(1);
  localparam logic [n_bits-1:0]         LastBit = n_bits'(DATA_width - 1);

  state_e                    state_q, state_d;
  logic [Prescale_width-1:0] edge_cnt_q, edge_cnt_d;
  logic [n_bits-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_width-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [Prescale_width-1:0] prescale_q, prescale_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;

  logic [Prescale_width-1:0] prescale_eff;
  logic                      bit_end;
  logic                      last_bit;
  logic [DATA_width-1:0]     data_sh;
  logic                      parity_bit;

  // Bit timing from the shadow prescale; a zero prescale counts as one cycle per bit.
  always_comb begin
    prescale_eff = (prescale_q == '0) ? PresOne : prescale_q;
    bit_end      = (edge_cnt_q == (prescale_eff - PresOne));
    last_bit     = (bit_cnt_q == LastBit);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each non-idle state lasts exactly one bit period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Data_Valid) state_d = StStart;
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && last_bit) state_d = par_en_q ? StParity : StStop;
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter and shadow next-state: shadows load only on acceptance in idle.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    prescale_d = prescale_q;

    if (state_q == StIdle) begin
      edge_cnt_d = '0;
      if (Data_Valid) begin
        data_d     = P_DATA;
        par_en_d   = PAR_EN;
        par_typ_d  = PAR_TYP;
        prescale_d = Prescale;
      end
    end else begin
      edge_cnt_d = bit_end ? '0 : (edge_cnt_q + PresOne);
    end

    // Clear on entry to the data phase, advance at every data-bit end.
    if (state_q == StStart && bit_end) begin
      bit_cnt_d = '0;
    end else if (state_q == StData && bit_end) begin
      bit_cnt_d = bit_cnt_q + BitOne;
    end
  end

  // Output decode from next-state values so the line and busy are glitch-free registers.
  always_comb begin
    data_sh    = data_d >> bit_cnt_d;
    parity_bit = par_typ_d ? ~^data_d : ^data_d;
    tx_d       = 1'b1;
    busy_d     = (state_d != StIdle);
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_sh[0];
      StParity: tx_d = parity_bit;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Datapath and output registers; reset abandons any frame and idles the line high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a table of directed frames plus hand-written
// sequences for back-to-back sends, requests while busy, and reset mid-frame.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       TX_OUT;
  logic       busy;

  uart_tx #(
    .Prescale_width(6),
    .DATA_width    (8),
    .n_bits        (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] data;
    logic [0:11] frame;  // line bits in transmit order, unused tail zero
    int         nb;
    int         len;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  logic cap [0:511];
  int   cap_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Pulse Data_Valid for one cycle; next sample must already show the start bit.
  task automatic send(input string name, input logic [5:0] p, input logic pe, input logic pt,
                      input logic [7:0] d);
    @(negedge clk);
    Prescale   = p;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    P_DATA     = d;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
    check({name, "_lat_busy"}, {31'b0, busy}, 32'd1);
    check({name, "_lat_tx"}, {31'b0, TX_OUT}, 32'd0);
  endtask

  // Record TX_OUT each cycle while busy; optionally inject a request at sample inj_at.
  task automatic capture(input int inj_at);
    cap_len = 0;
    while (busy === 1'b1 && cap_len < 500) begin
      cap[cap_len] = TX_OUT;
      if (inj_at >= 0 && cap_len == inj_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h55;
        Prescale   = 6'd2;
        PAR_EN     = 1'b1;
      end
      if (inj_at >= 0 && cap_len == inj_at + 1) Data_Valid = 1'b0;
      cap_len++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input logic [5:0] p, input logic [0:11] fr,
                             input int nb, input int len);
    int pe;
    int bad;
    pe = (p == 6'd0) ? 1 : int'(p);
    check({name, "_busy_len"}, cap_len, len);
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < pe; c++) begin
        if (cap[b * pe + c] !== fr[b]) bad++;
      end
      check($sformatf("%s_bit%0d_wrong_cycles", name, b), bad, 32'd0);
    end
    check({name, "_idle_tx"}, {31'b0, TX_OUT}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int bad;

    vecs[0] = '{"even_p8",   6'd8,  1'b1, 1'b0, 8'hA5, 12'b010100101010, 11, 88};
    vecs[1] = '{"odd_p16",   6'd16, 1'b1, 1'b1, 8'h01, 12'b010000000010, 11, 176};
    vecs[2] = '{"nopar_p0",  6'd0,  1'b0, 1'b0, 8'h5A, 12'b001011010100, 10, 10};
    vecs[3] = '{"nopar_p1",  6'd1,  1'b0, 1'b0, 8'h5A, 12'b001011010100, 10, 10};
    vecs[4] = '{"even_p3",   6'd3,  1'b1, 1'b0, 8'h07, 12'b011100000110, 11, 33};
    vecs[5] = '{"nopar_p2",  6'd2,  1'b0, 1'b1, 8'hC3, 12'b011000011100, 10, 20};

    reset_n    = 1'b0;
    Data_Valid = 1'b0;
    Prescale   = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    P_DATA     = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, TX_OUT}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].name, vecs[i].prescale, vecs[i].par_en, vecs[i].par_typ, vecs[i].data);
      capture(-1);
      check_frame(vecs[i].name, vecs[i].prescale, vecs[i].frame, vecs[i].nb, vecs[i].len);
      repeat (2) @(negedge clk);
    end

    // Back-to-back with Data_Valid held: exactly one idle cycle between frames.
    @(negedge clk);
    Prescale   = 6'd4;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    P_DATA     = 8'hFF;
    Data_Valid = 1'b1;
    @(negedge clk);
    check("b2b_lat_busy", {31'b0, busy}, 32'd1);
    P_DATA = 8'h00;
    capture(-1);
    check_frame("b2b_f1", 6'd4, 12'b011111111100, 10, 40);
    @(negedge clk);
    check("b2b_gap_busy", {31'b0, busy}, 32'd1);
    check("b2b_gap_tx", {31'b0, TX_OUT}, 32'd0);
    Data_Valid = 1'b0;
    capture(-1);
    check_frame("b2b_f2", 6'd4, 12'b000000000100, 10, 40);

    // Request while busy plus input changes mid-frame: frame unchanged, request dropped.
    repeat (2) @(negedge clk);
    send("busyreq", 6'd8, 1'b0, 1'b0, 8'h3C);
    capture(20);
    check_frame("busyreq", 6'd8, 12'b000111100100, 10, 80);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy !== 1'b0 || TX_OUT !== 1'b1) bad++;
      @(negedge clk);
    end
    check("busyreq_no_requeue", bad, 32'd0);

    // Reset during data bit 3, then a clean frame.
    send("rst", 6'd4, 1'b0, 1'b0, 8'h96);
    repeat (17) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", {31'b0, TX_OUT}, 32'd1);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_after_busy", {31'b0, busy}, 32'd0);
    send("rst_new", 6'd4, 1'b0, 1'b0, 8'h96);
    capture(-1);
    check_frame("rst_new", 6'd4, 12'b001101001100, 10, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
